// File: rtl/fmap_writer.sv
// Feature-map writeback engine: requantizes a raster stream of signed accumulators
// to int8 and issues one registered memory write per pixel, plane by plane.
module fmap_writer #(
  parameter int W     = 14,
  parameter int H     = 14,
  parameter int CH    = 16,
  parameter int AW    = 16,
  parameter int SHIFT = 4,
  parameter int RELU  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [AW-1:0] in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [4:0]    wr_ch,
  output logic [7:0]    wr_addr,
  output logic [7:0]    wr_data,
  output logic [4:0]    row,
  output logic [4:0]    col,
  output logic [4:0]    channel,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state_dbg
);

  // Handshake: a pixel is transferred on every rising edge where in_valid & in_ready;
  // in_ready depends only on state, never on in_valid.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic signed [AW-1:0] QMAX = AW'(127);
  localparam logic signed [AW-1:0] QMIN = AW'(-128);

  state_t      state_q, state_d;
  logic [4:0]  col_q, col_d, row_q, row_d, ch_q, ch_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_ch_q, wr_ch_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        hs;

  logic signed [AW-1:0] q_shr, q_cl;
  logic [7:0]           q8;

  // Floor-shift, optional ReLU, then saturate into int8.
  always_comb begin
    q_shr = $signed(in_data) >>> SHIFT;
    q_cl  = q_shr;
    if (RELU != 0 && q_shr < 0) q_cl = '0;
    if (q_cl > QMAX)      q8 = 8'h7f;
    else if (q_cl < QMIN) q8 = 8'h80;
    else                  q8 = q_cl[7:0];
  end

  assign hs = in_valid && (state_q == S_RUN);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    ch_d      = ch_q;
    wr_en_d   = 1'b0;
    wr_ch_d   = wr_ch_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (hs) begin
          wr_en_d   = 1'b1;
          wr_ch_d   = ch_q;
          wr_addr_d = 8'(row_q) * 8'(W) + 8'(col_q);
          wr_data_d = q8;
          if (col_q == 5'(W-1)) begin
            col_d = '0;
            if (row_q == 5'(H-1)) begin
              row_d = '0;
              if (ch_q == 5'(CH-1)) begin
                ch_d    = '0;
                state_d = S_DONE;
              end else begin
                ch_d = ch_q + 5'd1;
              end
            end else begin
              row_d = row_q + 5'd1;
            end
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      ch_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_ch_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      ch_q      <= ch_d;
      wr_en_q   <= wr_en_d;
      wr_ch_q   <= wr_ch_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign in_ready  = (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;
  assign wr_en     = wr_en_q;
  assign wr_ch     = wr_ch_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign row       = row_q;
  assign col       = col_q;
  assign channel   = ch_q;

endmodule

// File: doc/fmap_writer.md
# fmap_writer

Feature-map writeback engine: the write-side counterpart of the image/feature memory read path. Accepts a raster stream of wide signed accumulator results from a conv/dense stage, requantizes each to signed 8-bit, and issues one memory write per pixel at address `row*W + col` within the current channel plane. This is the only block that fills the feature memory between layers; it sits between the MAC array output and the memory write port.

## Interface
- `W`, 14, feature-map width in pixels.
- `H`, 14, feature-map height in pixels.
- `CH`, 16, number of channel planes, written in order 0..CH-1.
- `AW`, 16, accumulator input width, signed.
- `SHIFT`, 4, arithmetic right shift applied before saturation.
- `RELU`, 1, 1 = clamp negative results to 0.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a full write pass; sampled only in IDLE.
- `in_valid` in 1: upstream data valid.
- `in_data` in AW: signed accumulator value for the current pixel.
- `in_ready` out 1: writer can accept `in_data` this cycle.
- `wr_en` out 1: memory write strobe, one cycle per pixel.
- `wr_ch` out 5: channel plane select.
- `wr_addr` out 8: pixel address `row*W + col`.
- `wr_data` out 8: signed requantized pixel.
- `row`, `col`, `channel` out 5 each: position of the next pixel to be accepted.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse on the final write.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_ready`=0, counters held at 0. `start`=1 -> RUN, `busy`=1 from the next cycle.
- RUN: `in_ready`=1. Each handshake (`in_valid & in_ready`) captures one pixel and advances the counters:
  - `col` increments.
  - `col`==W-1 wraps to 0 and increments `row`.
  - `row`==H-1 also wraps and increments `channel`.
  - Handshake at (CH-1, H-1, W-1) -> DONE; counters wrap to 0.
- DONE: `in_ready`=0. Lasts exactly one cycle and carries the final write plus `done`=1, then -> IDLE.
- `busy`=1 in RUN and DONE.
- `start` outside IDLE is ignored; no restart mid-pass.
- `in_valid` gaps stall the pass indefinitely without producing writes.
- Requantization:
  - q = `in_data` >>> SHIFT, arithmetic, truncating toward -inf.
  - If RELU and q<0, q=0.
  - Saturate to [-128, 127].
- Address arithmetic: `wr_addr` = `row*W + col` computed at acceptance, 8 bits; W*H must be ≤256.
- Reset at any time:
  - state IDLE, counters 0.
  - The pending write is discarded; `wr_en` goes low immediately.
  - A partially written plane is left as-is.

## Timing
- Reset values:
  - `in_ready`, `wr_en`, `busy`, `done` = 0.
  - `wr_ch`, `wr_addr`, `wr_data`, `row`, `col`, `channel` = 0.
- Latency: handshake in cycle N -> `wr_en`=1 with that pixel's `wr_ch`/`wr_addr`/`wr_data` in cycle N+1.
- Throughput: one pixel per cycle; W*H*CH writes per pass, no bubbles when `in_valid` is held high.
- `row`/`col`/`channel` update in cycle N+1 after a handshake in cycle N.
- `done` coincides with the last `wr_en`.
- Total pass with continuous `in_valid`:
  - `start` at cycle 0.
  - RUN for cycles 1..3136.
  - DONE at cycle 3137 for default parameters.
- `wr_*` outputs are registered. `wr_en` is 0 in any cycle not following a handshake. `wr_ch`/`wr_addr`/`wr_data` hold their last value when `wr_en`=0.

## Test plan
- Reset then `start`:
  - Required outputs: `busy` rises at cycle 1; first handshake with `in_data`=0x0050 gives `wr_en`=1, `wr_ch`=0, `wr_addr`=0, `wr_data`=5 one cycle later.
  - Pass continues with `in_data`=16·k; required result: `wr_addr` sequence 0,1,…,195 in plane 0, then `wr_ch`=1 with `wr_addr`=0.
- Full continuous pass of 3136 beats:
  - Required result: exactly 3136 `wr_en` pulses.
  - `done`=1 only on the write with `wr_ch`=15, `wr_addr`=195.
  - `busy`=0 and `in_ready`=0 the following cycle.
- Requantization, SHIFT=4:
  - RELU=0: `in_data`=0x7FFF -> 127; -32768 -> -128; -24 -> -2 (floor); 0x07F0 -> 127.
  - RELU=1: -24 -> 0; 0x0030 -> 3.
- Random `in_valid` gaps, 30% idle:
  - No write during gaps.
  - Addresses are still contiguous, and the `wr_data` order matches the input order.
- Mid-pass reset at pixel (ch 3, row 7, col 9):
  - `wr_en` drops immediately; all outputs return to reset values.
  - New `start` restarts at `wr_ch`=0, `wr_addr`=0.
- `start` pulsed during RUN and `in_valid` held high in IDLE/DONE:
  - Required result: no counter disturbance and no extra writes.
